// File: rtl/alu_op_sequencer_pkg.sv
// alu_op_pkg: shared ALU opcode encoding, sequencer state type and latency helpers
package alu_op_pkg;
    localparam logic [4:0] OP_ADD       = 5'd3;
    localparam logic [4:0] OP_DIV       = 5'd15;
    localparam logic [4:0] OP_MUL       = 5'd16;
    localparam logic [4:0] OP_MAX_LEGAL = 5'd19;
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;
    function automatic logic is_legal_op(input logic [4:0] op);
        return op <= OP_MAX_LEGAL;
    endfunction
    function automatic int unsigned op_latency(input logic [4:0] op, input int unsigned mul_cycles,
                                               input int unsigned div_cycles);
        return op == OP_MUL ? mul_cycles : op == OP_DIV ? div_cycles : 32'd1;
    endfunction
endpackage

// File: rtl/alu_op_sequencer_if.sv
// alu_op_if: request, ALU operand/result and response bundle of the ALU sequencer
interface alu_op_if;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_opcode;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [4:0]  alu_opcode;
    logic [63:0] alu_c;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_hi;
    logic [31:0] rsp_lo;
    logic        rsp_illegal;
    logic        rsp_divzero;
    logic        busy;
    logic [15:0] ops_done;
    modport master (
        output req_valid, req_opcode, req_a, req_b, alu_c, rsp_ready,
        input  req_ready, alu_a, alu_b, alu_opcode, rsp_valid, rsp_hi, rsp_lo,
               rsp_illegal, rsp_divzero, busy, ops_done
    );
    modport slave (
        input  req_valid, req_opcode, req_a, req_b, alu_c, rsp_ready,
        output req_ready, alu_a, alu_b, alu_opcode, rsp_valid, rsp_hi, rsp_lo,
               rsp_illegal, rsp_divzero, busy, ops_done
    );
endinterface

// File: rtl/alu_op_timer.sv
// alu_op_timer: loadable down-counter that parks at zero and flags it
module alu_op_timer #(
    parameter int W = 3
) (
    input  logic         clock,
    input  logic         clear_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         zero_o
);
    logic [W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = load_i ? load_val_i : (cnt_q != '0 ? cnt_q - W'(1) : cnt_q);
    always_ff @(posedge clock) cnt_q <= !clear_n ? '0 : cnt_d;
    assign zero_o = cnt_q == '0;
endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: holds ALU operands stable for an opcode-dependent number of cycles,
// then captures the result (or an illegal/divide-by-zero substitute) into a response register.
module alu_op_sequencer
    import alu_op_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = 4,
    parameter int unsigned DIV_CYCLES = 8
) (
    input logic     clock,
    input logic     clear_n,
    alu_op_if.slave bus
);
    localparam int unsigned MAX_CYCLES = MUL_CYCLES > DIV_CYCLES ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW = MAX_CYCLES > 1 ? $clog2(MAX_CYCLES) : 1;
    state_e      state_q, state_d;
    logic [31:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d, rsp_hi_q, rsp_hi_d, rsp_lo_q, rsp_lo_d;
    logic [4:0]  alu_op_q, alu_op_d;
    logic        rsp_valid_q, rsp_valid_d, rsp_ill_q, rsp_ill_d, rsp_dz_q, rsp_dz_d, busy_q;
    logic [15:0] ops_q, ops_d;
    logic        accept, zero, illegal, divzero;
    logic [CW-1:0] load_val;
    alu_op_timer #(.W(CW)) u_timer (
        .clock      (clock),
        .clear_n    (clear_n),
        .load_i     (accept),
        .load_val_i (load_val),
        .zero_o     (zero)
    );
    assign bus.req_ready = state_q == IDLE || (state_q == DONE && bus.rsp_ready);
    assign accept   = bus.req_valid && bus.req_ready;
    assign load_val = CW'(op_latency(bus.req_opcode, MUL_CYCLES, DIV_CYCLES) - 32'd1);
    assign illegal  = !is_legal_op(alu_op_q);
    assign divzero  = alu_op_q == OP_DIV && alu_b_q == '0;
    always_comb begin
        state_d     = state_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_op_d    = alu_op_q;
        rsp_hi_d    = rsp_hi_q;
        rsp_lo_d    = rsp_lo_q;
        rsp_valid_d = rsp_valid_q;
        rsp_ill_d   = rsp_ill_q;
        rsp_dz_d    = rsp_dz_q;
        ops_d       = ops_q;
        if (state_q == EXEC && zero) begin
            state_d     = DONE;
            rsp_valid_d = 1'b1;
            rsp_ill_d   = illegal;
            rsp_dz_d    = divzero;
            rsp_hi_d    = illegal ? '0 : divzero ? '1 : bus.alu_c[63:32];
            rsp_lo_d    = illegal ? '0 : divzero ? alu_a_q : bus.alu_c[31:0];
        end
        if (state_q == DONE && bus.rsp_ready) begin
            state_d     = IDLE;
            rsp_valid_d = 1'b0;
            ops_d       = ops_q + 16'd1;
        end
        // an accept in DONE overrides the return to IDLE (back-to-back issue)
        if (accept) begin
            state_d  = EXEC;
            alu_a_d  = bus.req_a;
            alu_b_d  = bus.req_b;
            alu_op_d = bus.req_opcode;
        end
    end
    always_ff @(posedge clock) begin
        if (!clear_n) begin
            state_q     <= IDLE;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            rsp_hi_q    <= '0;
            rsp_lo_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_ill_q   <= 1'b0;
            rsp_dz_q    <= 1'b0;
            busy_q      <= 1'b0;
            ops_q       <= '0;
        end else begin
            state_q     <= state_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            rsp_hi_q    <= rsp_hi_d;
            rsp_lo_q    <= rsp_lo_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_ill_q   <= rsp_ill_d;
            rsp_dz_q    <= rsp_dz_d;
            busy_q      <= state_d != IDLE;
            ops_q       <= ops_d;
        end
    end
    assign bus.alu_a       = alu_a_q;
    assign bus.alu_b       = alu_b_q;
    assign bus.alu_opcode  = alu_op_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_hi      = rsp_hi_q;
    assign bus.rsp_lo      = rsp_lo_q;
    assign bus.rsp_illegal = rsp_ill_q;
    assign bus.rsp_divzero = rsp_dz_q;
    assign bus.busy        = busy_q;
    assign bus.ops_done    = ops_q;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed and random operations against a transaction-level response model
module tb_alu_op_sequencer;
    import alu_op_pkg::*;
    localparam int MUL_N = 4;
    localparam int DIV_N = 8;
    logic clock = 1'b0;
    logic clear_n = 1'b0;
    alu_op_if bus ();
    alu_op_sequencer #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
        .clock   (clock),
        .clear_n (clear_n),
        .bus     (bus)
    );
    always #5 clock = ~clock;
    int n_vec = 0;
    int n_err = 0;
    logic [15:0] ops_exp = '0;
    logic [4:0]  cur_op;
    logic [31:0] cur_a, cur_b;
    logic [65:0] exp_rsp;
    // stand-in combinational ALU: divide gives {quotient, remainder}, junk on B = 0
    function automatic logic [63:0] alu_fn(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op == 5'd3)  return {32'd0, a + b};
        if (op == 5'd16) return {32'd0, a} * {32'd0, b};
        if (op == 5'd15) return b != 0 ? {a / b, a % b} : 64'hDEAD_BEEF_CAFE_F00D;
        return {a ^ b, ~a + {27'd0, op}};
    endfunction
    assign bus.alu_c = alu_fn(bus.alu_opcode, bus.alu_a, bus.alu_b);
    // expected response {illegal, divzero, hi, lo} and latency from the request alone
    function automatic logic [65:0] model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op > 5'd19) return {2'b10, 64'd0};
        if (op == 5'd15 && b == 0) return {2'b01, 32'hFFFF_FFFF, a};
        return {2'b00, alu_fn(op, a, b)};
    endfunction
    function automatic int lat(input logic [4:0] op);
        return op == 5'd16 ? MUL_N : op == 5'd15 ? DIV_N : 1;
    endfunction
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask
    task automatic reset_dut();
        clear_n = 1'b0;
        @(posedge clock); #1;
        check("rst_flags", {bus.rsp_valid, bus.rsp_illegal, bus.rsp_divzero, bus.busy}, 0);
        check("rst_rsp", {bus.rsp_hi, bus.rsp_lo}, 0);
        check("rst_alu", {bus.alu_a, bus.alu_b}, 0);
        check("rst_op", bus.alu_opcode, 0);
        check("rst_ops", bus.ops_done, 0);
        clear_n = 1'b1;
        ops_exp = '0;
        @(posedge clock); #1;
        check("rst_ready", bus.req_ready, 1);
    endtask
    task automatic accept(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input bit with_rsp);
        bus.req_valid = 1'b1;
        bus.req_opcode = op;
        bus.req_a = a;
        bus.req_b = b;
        bus.rsp_ready = with_rsp;
        #1;
        check("req_ready", bus.req_ready, 1);
        @(posedge clock); #1;
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        bus.req_opcode = 5'($urandom);
        bus.req_a = $urandom;
        bus.req_b = $urandom;
        cur_op = op;
        cur_a = a;
        cur_b = b;
        if (with_rsp) begin
            ops_exp++;
            check("ops_b2b", bus.ops_done, ops_exp);
        end
        check("busy_exec", bus.busy, 1);
        check("valid_exec", bus.rsp_valid, 0);
        check("alu_ab", {bus.alu_a, bus.alu_b}, {a, b});
        check("alu_op", bus.alu_opcode, op);
    endtask
    task automatic wait_rsp();
        int cyc = 0;
        exp_rsp = model(cur_op, cur_a, cur_b);
        while (!bus.rsp_valid && cyc < 40) begin
            @(posedge clock); #1;
            cyc++;
            check("alu_hold", {bus.alu_a, bus.alu_b}, {cur_a, cur_b});
            check("op_hold", bus.alu_opcode, cur_op);
        end
        check("latency", cyc, lat(cur_op));
        check("rsp_data", {bus.rsp_hi, bus.rsp_lo}, exp_rsp[63:0]);
        check("rsp_flags", {bus.rsp_illegal, bus.rsp_divzero}, exp_rsp[65:64]);
        check("busy_done", bus.busy, 1);
    endtask
    task automatic hold_rsp(input int n);
        repeat (n) begin
            @(posedge clock); #1;
            check("hold_valid", {bus.rsp_valid, bus.req_ready}, 2'b10);
            check("hold_data", {bus.rsp_hi, bus.rsp_lo}, exp_rsp[63:0]);
            check("hold_flags", {bus.rsp_illegal, bus.rsp_divzero}, exp_rsp[65:64]);
        end
    endtask
    task automatic release_rsp();
        bus.rsp_ready = 1'b1;
        #1;
        check("ready_done", bus.req_ready, 1);
        @(posedge clock); #1;
        bus.rsp_ready = 1'b0;
        ops_exp++;
        check("ops_done", bus.ops_done, ops_exp);
        check("post_hs", {bus.rsp_valid, bus.busy, bus.req_ready}, 3'b001);
    endtask
    function automatic logic [4:0] rand_op();
        case ($urandom_range(0, 4))
            0: return 5'd16;
            1: return 5'd15;
            2: return 5'($urandom_range(20, 31));
            default: return 5'($urandom_range(0, 19));
        endcase
    endfunction
    function automatic logic [31:0] rand_b();
        return $urandom_range(0, 3) == 0 ? 32'd0 : $urandom;
    endfunction
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end
    initial begin
        bus.req_valid = 1'b0;
        bus.req_opcode = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.rsp_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset_dut();
        accept(OP_ADD, 32'd7, 32'd5, 1'b0);
        wait_rsp();
        check("add_const", {bus.rsp_hi, bus.rsp_lo}, 64'd12);
        release_rsp();
        accept(OP_MUL, 32'h10000, 32'h10000, 1'b0);
        wait_rsp();
        check("mul_const", {bus.rsp_hi, bus.rsp_lo}, 64'h1_0000_0000);
        release_rsp();
        accept(OP_DIV, 32'd100, 32'd7, 1'b0);
        wait_rsp();
        check("div_const", {bus.rsp_hi, bus.rsp_lo}, {32'd14, 32'd2});
        release_rsp();
        accept(OP_DIV, 32'd9, 32'd0, 1'b0);
        wait_rsp();
        check("divzero_const", {bus.rsp_divzero, bus.rsp_hi, bus.rsp_lo}, {1'b1, 32'hFFFF_FFFF, 32'd9});
        release_rsp();
        accept(5'h1F, $urandom, $urandom, 1'b0);
        wait_rsp();
        release_rsp();
        accept(OP_ADD, 32'd1, 32'd2, 1'b0);
        wait_rsp();
        hold_rsp(5);
        accept(OP_MUL, 32'd3, 32'd4, 1'b1);
        wait_rsp();
        release_rsp();
        accept(OP_DIV, 32'd50, 32'd5, 1'b0);
        repeat (3) @(posedge clock);
        #1;
        reset_dut();
        repeat (12) begin
            @(posedge clock); #1;
            check("no_rsp", {bus.rsp_valid, bus.busy}, 0);
        end
        force dut.ops_q = 16'hFFFF;
        @(posedge clock); #1;
        release dut.ops_q;
        ops_exp = 16'hFFFF;
        @(posedge clock); #1;
        check("preload", bus.ops_done, 16'hFFFF);
        accept(OP_ADD, 32'd1, 32'd1, 1'b0);
        wait_rsp();
        release_rsp();
        check("wrap", bus.ops_done, 16'd0);
        accept(rand_op(), $urandom, rand_b(), 1'b0);
        wait_rsp();
        for (int i = 0; i < 50; i++) begin
            hold_rsp($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) begin
                accept(rand_op(), $urandom, rand_b(), 1'b1);
            end else begin
                release_rsp();
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clock); #1;
                end
                check("idle_hold", {bus.alu_a, bus.alu_b}, {cur_a, cur_b});
                accept(rand_op(), $urandom, rand_b(), 1'b0);
            end
            wait_rsp();
        end
        release_rsp();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Multi-cycle controller that sits between the control unit and the combinational ALU. It accepts one operation per valid/ready handshake, holds the operands and opcode stable on the ALU inputs for an opcode-dependent number of cycles, then captures the 64-bit ALU result into a response register. Holding the inputs stable lets Multiply and Divide be constrained as multicycle paths. It also flags illegal opcodes and divide-by-zero, and counts completed operations.

## Interface
- MUL_CYCLES, default 4: cycles from accept to `rsp_valid` for Multiply (≥1).
- DIV_CYCLES, default 8: cycles from accept to `rsp_valid` for Divide (≥1).
- clock  in  1  single clock; all state updates on the rising edge.
- clear_n  in  1  reset, synchronous, active-low.
- req_valid  in  1  operation request.
- req_ready  out  1  sequencer can accept a request this cycle.
- req_opcode  in  5  ALU opcode, using the shared encoding.
- req_a, req_b  in  32 each  operands.
- alu_a, alu_b  out  32 each  registered operands driven to the ALU.
- alu_opcode  out  5  registered opcode driven to the ALU.
- alu_c  in  64  combinational ALU result.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts the result.
- rsp_hi, rsp_lo  out  32 each  result[63:32] and result[31:0].
- rsp_illegal  out  1  opcode was outside 0–19.
- rsp_divzero  out  1  Divide was issued with B = 0.
- busy  out  1  high in EXEC or DONE.
- ops_done  out  16  count of completed response handshakes; wraps at 0xFFFF→0.

## Operation
- **States:**
  - IDLE: `req_ready` = 1.
  - EXEC: down-counter running.
  - DONE: `rsp_valid` = 1.
- **Accept.** A request is accepted when `req_valid & req_ready`. On accept, register `req_a`, `req_b` and `req_opcode` into `alu_a`, `alu_b` and `alu_opcode`, then load the counter with L−1.
- **Latency L:**
  - Multiply (5'b10000): MUL_CYCLES.
  - Divide (5'b01111): DIV_CYCLES.
  - Every other legal opcode (0–19, including ld/ldi/st/br): 1.
  - Illegal opcode (20–31): 1.
- **EXEC.** Decrement the counter each cycle. On the edge where the counter is 0, capture the result and move to DONE. When L = 1, the capture happens on the first edge after accept.
- **Capture rules:**
  - Legal opcode, not divide-by-zero: `{rsp_hi, rsp_lo}` ← `alu_c`.
  - Illegal opcode: `rsp_hi` = `rsp_lo` = 0 and `rsp_illegal` = 1.
  - Divide with `alu_b` = 0: `rsp_hi` = 0xFFFFFFFF (quotient), `rsp_lo` = `alu_a` (remainder), `rsp_divzero` = 1. `alu_c` is ignored.
- **DONE.** `rsp_valid` and all `rsp_*` fields hold stable until `rsp_ready`.
  - On `rsp_valid & rsp_ready`: increment `ops_done`.
  - If `req_valid` is also high in that cycle, accept the new request directly (back-to-back) and go to EXEC.
  - Otherwise go to IDLE.
- **`req_ready`** = (state == IDLE) | (state == DONE & `rsp_ready`).
- **Operand stability.** `alu_a`, `alu_b` and `alu_opcode` change only on accept. They hold their last value while in IDLE.

## Timing
- **Reset.** `clear_n` low at any rising edge does the following, regardless of state:
  - State → IDLE; counter = 0.
  - `alu_a`, `alu_b`, `rsp_hi`, `rsp_lo` = 0; `alu_opcode` = 0; `ops_done` = 0.
  - `rsp_valid`, `rsp_illegal`, `rsp_divzero`, `busy` = 0.
  - Any in-flight operation is discarded and produces no response.
- **After reset.** `req_ready` = 1 from the first cycle after `clear_n` returns high.
- **Latency.** Accept at edge N gives `rsp_valid` high from edge N+L.
- **Throughput.** With `rsp_ready` tied high, a stream of L = 1 operations completes one every 2 cycles.
- **Registered outputs.** `rsp_*` and `busy` are registered. `req_ready` is combinational from state and `rsp_ready` only.
- **Input sampling.** Request fields are sampled only on the accept edge. Changes at any other time are ignored.

## Structure
- **Shared package `alu_op_pkg`** contains:
  - The 5-bit opcode localparams, shared with the ALU and the control unit.
  - The state enum {IDLE, EXEC, DONE}.
  - A `op_latency(opcode, MUL_CYCLES, DIV_CYCLES)` function.
  - An `is_legal_op` function.
- **Sub-module `alu_op_timer`:** a loadable down-counter with a `zero` flag, sized to $clog2(max(MUL_CYCLES, DIV_CYCLES)).
- **No ALU inside this block.** The ALU is instantiated alongside it in the datapath.

## Test plan
- **Simple add:** reset, then Add (5'b00011) with A = 7, B = 5. Expect `rsp_valid` 1 cycle after accept with hi = 0, lo = 12, `busy` low after the handshake, and `ops_done` = 1.
- **Multiply:** A = 0x10000, B = 0x10000 with MUL_CYCLES = 4. Expect `rsp_valid` exactly 4 cycles after accept with hi = 0x1, lo = 0. `alu_a`, `alu_b` and `alu_opcode` are stable across all 4 cycles.
- **Divide:**
  - A = 100, B = 7 → hi = 14, lo = 2.
  - A = 9, B = 0 → `rsp_divzero` = 1, hi = 0xFFFFFFFF, lo = 9.
- **Illegal opcode:** opcode 5'b11111 → after 1 cycle, `rsp_illegal` = 1, hi = lo = 0, and the next request is accepted normally.
- **Backpressure and back-to-back:** hold `rsp_ready` low for 5 cycles. The response stays stable and `req_ready` stays 0. Then raise `rsp_ready` with `req_valid` high: the new op is accepted in the same cycle and `ops_done` increments once.
- **Reset mid-operation:** start a Divide, then drop `clear_n` for 1 edge during EXEC. Expect no response, all outputs at reset values, and `ops_done` = 0. Preload `ops_done` to 0xFFFF and complete one op: it wraps to 0.
